// File: rtl/hd_run_scheduler.sv
// HD inference run sequencer: phased host-stream load, then encode and check handshakes.
// Optional watchdog on the ENCODE/CHECK waits is enabled by defining HD_SCHED_WATCHDOG_EN.
module hd_run_scheduler #(
    parameter int PROJ_WORDS  = 125,
    parameter int FEA_WORDS   = 128,
    parameter int CLA_WORDS   = 104000,
    parameter int CLASS_NUM   = 26,
    parameter int CNT_WIDTH   = 17,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 host_valid,
    output logic                 host_ready,
    output logic                 proj_we,
    output logic                 fea_we,
    output logic                 cla_we,
    output logic                 coef_we,
    output logic                 run_encode,
    input  logic                 encode_done,
    output logic                 run_check,
    input  logic                 check_done,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, LD_PROJ = 3'd1, LD_FEA = 3'd2, LD_CLA = 3'd3,
        ENCODE = 3'd4, CHECK = 3'd5, FIN = 3'd6, ERR = 3'd7
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PROJ_LAST = CNT_WIDTH'(PROJ_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] FEA_LAST  = CNT_WIDTH'(FEA_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CLA_LAST  = CNT_WIDTH'(CLA_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] COEF_LIM  = CNT_WIDTH'(CLASS_NUM);

    state_t state, state_n;
    logic   accept;
    logic   wd_timeout;

    assign accept = host_valid & host_ready;

`ifdef HD_SCHED_WATCHDOG_EN
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYC - 1);
    logic [CNT_WIDTH-1:0] wd_cnt;

    // Restarts on every state change, so each wait gets its own full budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                wd_cnt <= '0;
        else if (state_n != state)                 wd_cnt <= '0;
        else if (state == ENCODE || state == CHECK) wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_timeout = (wd_cnt == WD_LAST);
    assign error      = (state == ERR);
`else
    assign wd_timeout = 1'b0;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Cleared on any phase change so each load phase counts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         beat_cnt <= '0;
        else if (abort || state_n != state) beat_cnt <= '0;
        else if (accept)                    beat_cnt <= beat_cnt + 1'b1;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LD_PROJ;
            LD_PROJ: if (accept && beat_cnt == PROJ_LAST) state_n = LD_FEA;
            LD_FEA:  if (accept && beat_cnt == FEA_LAST)  state_n = LD_CLA;
            LD_CLA:  if (accept && beat_cnt == CLA_LAST)  state_n = ENCODE;
            ENCODE:  if (encode_done) state_n = CHECK;
                     else if (wd_timeout) state_n = ERR;
            CHECK:   if (check_done) state_n = FIN;
                     else if (wd_timeout) state_n = ERR;
            FIN:     state_n = IDLE;
            ERR:     if (start) state_n = LD_PROJ;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_comb begin
        host_ready = (state == LD_PROJ) || (state == LD_FEA) || (state == LD_CLA);
        proj_we    = accept && (state == LD_PROJ);
        fea_we     = accept && (state == LD_FEA);
        cla_we     = accept && (state == LD_CLA);
        coef_we    = accept && (state == LD_CLA) && (beat_cnt < COEF_LIM);
        run_encode = (state == ENCODE);
        run_check  = (state == CHECK);
        done       = (state == FIN);
        busy       = (state != IDLE);
        phase      = state;
    end
endmodule

// File: tb/tb_hd_run_scheduler.sv
// Scoreboard bench for hd_run_scheduler: expected strobe/done events are queued by the
// stimulus and consumed by a negedge monitor; state snapshots are checked directly.
module tb_hd_run_scheduler;
    localparam int CW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, abort = 1'b0, host_valid = 1'b0;
    logic          encode_done = 1'b0, check_done = 1'b0;
    logic          host_ready, proj_we, fea_we, cla_we, coef_we;
    logic          run_encode, run_check, busy, done, error;
    logic [2:0]    phase;
    logic [CW-1:0] beat_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0]    ph;
        logic [CW-1:0] cnt;
        logic [4:0]    str;   // {proj, fea, cla, coef, done}
    } ev_t;

    ev_t exp_q[$];

    localparam logic [4:0] S_PROJ = 5'b10000, S_FEA = 5'b01000, S_CLA = 5'b00100,
                           S_COEF = 5'b00010, S_DONE = 5'b00001;

    hd_run_scheduler #(
        .PROJ_WORDS(4), .FEA_WORDS(3), .CLA_WORDS(5), .CLASS_NUM(2),
        .CNT_WIDTH(CW), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_valid(host_valid), .host_ready(host_ready),
        .proj_we(proj_we), .fea_we(fea_we), .cla_we(cla_we), .coef_we(coef_we),
        .run_encode(run_encode), .encode_done(encode_done),
        .run_check(run_check), .check_done(check_done),
        .phase(phase), .beat_cnt(beat_cnt), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe or done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (proj_we || fea_we || cla_we || done) begin
            ev_t obs, e;
            obs = '{ph: phase, cnt: beat_cnt, str: {proj_we, fea_we, cla_we, coef_we, done}};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event got=%h expected=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL event got=%h expected=%h", obs, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    task automatic push_ev(input logic [2:0] ph, input int c, input logic [4:0] s);
        exp_q.push_back('{ph: ph, cnt: CW'(c), str: s});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_proj_fea();
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin push_ev(3'd1, i, S_PROJ); tick(); end
        for (int i = 0; i < 3; i++) begin push_ev(3'd2, i, S_FEA); tick(); end
    endtask

    task automatic load_cla(input int n);
        host_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            push_ev(3'd3, i, (i < 2) ? (S_CLA | S_COEF) : S_CLA);
            tick();
        end
        host_valid = 1'b0;
    endtask

    task automatic finish_run();
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        push_ev(3'd6, 0, S_DONE);
        chk("fin_phase", phase, 3'd6);
        chk("fin_busy", busy, 1'b1);
        tick();
        chk("after_fin_phase", phase, 3'd0);
        chk("after_fin_busy", busy, 1'b0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_phase", phase, 3'd0);
        chk("rst_outputs", {host_ready, proj_we, fea_we, cla_we, coef_we,
                            run_encode, run_check, busy, done, error}, 10'd0);
        chk("rst_beat_cnt", beat_cnt, 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: continuous stream, full run
        host_valid = 1'b1;
        chk("idle_ready", host_ready, 1'b0);
        host_valid = 1'b0;
        do_start();
        chk("t1_phase_proj", phase, 3'd1);
        chk("t1_ready", host_ready, 1'b1);
        load_proj_fea();
        chk("t1_phase_cla", phase, 3'd3);
        load_cla(5);
        chk("t1_phase_enc", phase, 3'd4);
        chk("t1_run_encode", run_encode, 1'b1);
        chk("t1_ready_enc", host_ready, 1'b0);
        encode_done = 1'b1;
        tick();
        encode_done = 1'b0;
        chk("t1_phase_chk", phase, 3'd5);
        chk("t1_run_check", {run_check, run_encode}, 2'b10);
        finish_run();

        // 2: toggling host_valid in LD_FEA
        do_start();
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin push_ev(3'd1, i, S_PROJ); tick(); end
        for (int k = 0; k < 6; k++) begin
            host_valid = k[0];
            if (k[0]) push_ev(3'd2, k / 2, S_FEA);
            tick();
            if (k < 5) begin
                chk("t2_phase", phase, 3'd2);
                chk("t2_beat_cnt", beat_cnt, (k + 1) / 2);
            end
        end
        host_valid = 1'b0;
        chk("t2_phase_cla", phase, 3'd3);
        chk("t2_beat_cnt_clr", beat_cnt, 0);
        load_cla(5);

        // 3: out-of-state inputs ignored
        start = 1'b1; check_done = 1'b1;
        tick();
        start = 1'b0; check_done = 1'b0;
        chk("t3_enc_hold", phase, 3'd4);
        encode_done = 1'b1;
        tick();
        encode_done = 1'b0;
        chk("t3_to_check", phase, 3'd5);
        encode_done = 1'b1; start = 1'b1;
        tick();
        encode_done = 1'b0; start = 1'b0;
        chk("t3_chk_hold", phase, 3'd5);
        finish_run();

        // 4: abort on last LD_CLA beat
        do_start();
        load_proj_fea();
        load_cla(4);
        host_valid = 1'b1; abort = 1'b1;
        push_ev(3'd3, 4, S_CLA);
        tick();
        host_valid = 1'b0; abort = 1'b0;
        chk("t4_phase", phase, 3'd0);
        chk("t4_beat_cnt", beat_cnt, 0);
        chk("t4_busy", busy, 1'b0);
        tick();
        chk("t4_no_done_phase", phase, 3'd0);

        // 5: watchdog (or indefinite wait) in ENCODE
        do_start();
        load_proj_fea();
        load_cla(5);
        for (int i = 0; i < 9; i++) tick();
        chk("t5_enc_9cyc", phase, 3'd4);
        tick();
`ifdef HD_SCHED_WATCHDOG_EN
        chk("t5_phase_err", phase, 3'd7);
        chk("t5_error", error, 1'b1);
        chk("t5_err_quiet", {busy, run_encode, run_check, host_ready}, 4'b1000);
        do_start();
        chk("t5_restart", phase, 3'd1);
        chk("t5_error_clr", error, 1'b0);
`else
        chk("t5_phase_enc", phase, 3'd4);
        chk("t5_error", error, 1'b0);
        do_start();
        chk("t5_start_ignored", phase, 3'd4);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort", {phase, error}, 4'd0);

        // 6: async reset mid-load
        do_start();
        host_valid = 1'b1;
        push_ev(3'd1, 0, S_PROJ); tick();
        push_ev(3'd1, 1, S_PROJ); tick();
        chk("t6_beat2", beat_cnt, 2);
        reset = 1'b0;
        #1;
        chk("t6_rst_phase", phase, 3'd0);
        chk("t6_rst_outs", {host_ready, proj_we, busy, done, error}, 5'd0);
        chk("t6_rst_cnt", beat_cnt, 0);
        host_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("t6_after_phase", phase, 3'd0);
        chk("t6_after_busy", busy, 1'b0);

        tick();
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event got=none expected=%h", e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
